// File: rtl/pong_pkg.sv
// Shared definitions for the pong engine: FSM state encoding, score width
// and paddle geometry helpers used by both the engine and the renderer.
package pong_pkg;

  localparam int SCORE_W = 4;
  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  function automatic int clamp_pad(int p, int width, int pad);
    return (p > width - pad) ? width - pad : p;
  endfunction

  // Paddle [p, p+pad-1] overlaps [x-1, x+1]; an in-range paddle can never
  // overlap the off-screen columns -1 or WIDTH, so no extra masking is needed.
  function automatic logic paddle_hit(int p, int x, int pad);
    return (p <= x + 1) && (p + pad >= x);
  endfunction

  function automatic score_t sat_inc(score_t s, int lim);
    return (int'(s) >= lim) ? s : s + score_t'(1);
  endfunction

endpackage

// File: rtl/pong_engine_if.sv
// Player/display bus of the pong engine. The engine is the slave; the board
// (or testbench) drives tick/start/paddles/row_sel as master.
interface pong_engine_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
);
  import pong_pkg::*;

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic              tick;
  logic              start;
  logic [XW-1:0]     player_top;
  logic [XW-1:0]     player_down;
  logic [YW-1:0]     row_sel;
  logic [WIDTH-1:0]  matrix_out;
  logic [XW-1:0]     ball_x;
  logic [YW-1:0]     ball_y;
  logic [1:0]        state;
  logic              hit_top;
  logic              hit_down;
  logic              point_top;
  logic              point_down;
  score_t            score_top;
  score_t            score_down;

  modport master (
    output tick, start, player_top, player_down, row_sel,
    input  matrix_out, ball_x, ball_y, state, hit_top, hit_down,
           point_top, point_down, score_top, score_down
  );

  modport slave (
    input  tick, start, player_top, player_down, row_sel,
    output matrix_out, ball_x, ball_y, state, hit_top, hit_down,
           point_top, point_down, score_top, score_down
  );

endinterface

// File: rtl/pong_render.sv
// Row scan-out of the pong field: clamped paddles on the edge rows plus the
// ball pixel, registered with one cycle of latency from row_sel.
module pong_render
  import pong_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int PAD_SIZE = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(HEIGHT)-1:0] row_sel_i,
  input  logic [$clog2(WIDTH)-1:0]  player_top_i,
  input  logic [$clog2(WIDTH)-1:0]  player_down_i,
  input  logic [$clog2(WIDTH)-1:0]  ball_x_i,
  input  logic [$clog2(HEIGHT)-1:0] ball_y_i,
  input  logic                      show_ball_i,
  output logic [WIDTH-1:0]          matrix_o
);

  logic [WIDTH-1:0] row_d, row_q;
  int               pt_s, pd_s;
  logic             top_row_s, down_row_s, ball_row_s;

  always_comb begin
    pt_s       = clamp_pad(int'(player_top_i), WIDTH, PAD_SIZE);
    pd_s       = clamp_pad(int'(player_down_i), WIDTH, PAD_SIZE);
    top_row_s  = (int'(row_sel_i) == 0);
    down_row_s = (int'(row_sel_i) == HEIGHT - 1);
    ball_row_s = show_ball_i && (row_sel_i == ball_y_i);
    row_d      = '0;
    for (int c = 0; c < WIDTH; c++) begin
      row_d[c] = (top_row_s  && (c >= pt_s) && (c < pt_s + PAD_SIZE)) ||
                 (down_row_s && (c >= pd_s) && (c < pd_s + PAD_SIZE)) ||
                 (ball_row_s && (int'(ball_x_i) == c));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign matrix_o = row_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game engine: serve/play/point/game-over FSM, ball motion with wall
// bounces, paddle collision and scoring; drawing is done by pong_render.
module pong_engine
  import pong_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int PAD_SIZE  = 2,
  parameter int WIN_SCORE = 9
) (
  input logic          clk,
  input logic          reset,
  pong_engine_if.slave bus
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_MID = XW'(WIDTH / 2);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MID = YW'(HEIGHT / 2);
  localparam logic [YW-1:0] Y_TOP = YW'(1);
  localparam logic [YW-1:0] Y_BOT = YW'(HEIGHT - 2);
  localparam score_t        WIN   = score_t'(WIN_SCORE);

  state_e        state_q, state_d;
  score_t        score_top_q, score_top_d, score_down_q, score_down_d;
  logic [XW-1:0] ball_x_q, ball_x_d;
  logic [YW-1:0] ball_y_q, ball_y_d;
  logic          dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic          hit_top_q, hit_top_d, hit_down_q, hit_down_d;
  logic          point_top_q, point_top_d, point_down_q, point_down_d;
  logic          dx_flip_s, top_hit_s, down_hit_s;

  always_comb begin
    top_hit_s  = paddle_hit(clamp_pad(int'(bus.player_top), WIDTH, PAD_SIZE),
                            int'(ball_x_q), PAD_SIZE);
    down_hit_s = paddle_hit(clamp_pad(int'(bus.player_down), WIDTH, PAD_SIZE),
                            int'(ball_x_q), PAD_SIZE);
    dx_flip_s  = dx_neg_q ? (ball_x_q == '0) : (ball_x_q == X_MAX);

    state_d      = state_q;
    score_top_d  = score_top_q;
    score_down_d = score_down_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    dx_neg_d     = dx_neg_q;
    dy_neg_d     = dy_neg_q;
    hit_top_d    = 1'b0;
    hit_down_d   = 1'b0;
    point_top_d  = 1'b0;
    point_down_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d      = ST_PLAY;
          score_top_d  = '0;
          score_down_d = '0;
          ball_x_d     = X_MID;
          ball_y_d     = Y_MID;
          dx_neg_d     = 1'b0;
          dy_neg_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_PLAY: begin
        if (bus.tick) begin
          dx_neg_d = dx_neg_q ^ dx_flip_s;
          ball_x_d = dx_neg_d ? ball_x_q - XW'(1) : ball_x_q + XW'(1);
          if (dy_neg_q && (ball_y_q == Y_TOP)) begin
            if (top_hit_s) begin
              dy_neg_d  = 1'b0;
              ball_y_d  = YW'(2);
              hit_top_d = 1'b1;
            end else begin
              ball_y_d     = '0;
              score_down_d = sat_inc(score_down_q, WIN_SCORE);
              point_down_d = 1'b1;
              state_d      = ST_POINT;
            end
          end else if (!dy_neg_q && (ball_y_q == Y_BOT)) begin
            if (down_hit_s) begin
              dy_neg_d   = 1'b1;
              ball_y_d   = YW'(HEIGHT - 3);
              hit_down_d = 1'b1;
            end else begin
              ball_y_d    = YW'(HEIGHT - 1);
              score_top_d = sat_inc(score_top_q, WIN_SCORE);
              point_top_d = 1'b1;
              state_d     = ST_POINT;
            end
          end else begin
            ball_y_d = dy_neg_q ? ball_y_q - YW'(1) : ball_y_q + YW'(1);
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      // dy is untouched by a miss, so keeping it re-serves toward the loser.
      ST_POINT: begin
        if ((score_top_q == WIN) || (score_down_q == WIN)) begin
          state_d = ST_OVER;
        end else if (bus.start) begin
          state_d  = ST_PLAY;
          ball_x_d = X_MID;
          ball_y_d = Y_MID;
        end else begin
          state_d = ST_POINT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      score_top_q  <= '0;
      score_down_q <= '0;
      ball_x_q     <= X_MID;
      ball_y_q     <= Y_MID;
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      hit_top_q    <= 1'b0;
      hit_down_q   <= 1'b0;
      point_top_q  <= 1'b0;
      point_down_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_top_q  <= score_top_d;
      score_down_q <= score_down_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dx_neg_q     <= dx_neg_d;
      dy_neg_q     <= dy_neg_d;
      hit_top_q    <= hit_top_d;
      hit_down_q   <= hit_down_d;
      point_top_q  <= point_top_d;
      point_down_q <= point_down_d;
    end
  end

  pong_render #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .PAD_SIZE (PAD_SIZE)
  ) u_render (
    .clk           (clk),
    .reset         (reset),
    .row_sel_i     (bus.row_sel),
    .player_top_i  (bus.player_top),
    .player_down_i (bus.player_down),
    .ball_x_i      (ball_x_q),
    .ball_y_i      (ball_y_q),
    .show_ball_i   (state_q != ST_IDLE),
    .matrix_o      (bus.matrix_out)
  );

  assign bus.state      = state_q;
  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q;
  assign bus.score_top  = score_top_q;
  assign bus.score_down = score_down_q;
  assign bus.hit_top    = hit_top_q;
  assign bus.hit_down   = hit_down_q;
  assign bus.point_top  = point_top_q;
  assign bus.point_down = point_down_q;

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: a directed opening with hand-computed values, then
// random play, all compared every cycle against a rule-level game model.
module tb_pong_engine;

  localparam int W   = 8;
  localparam int H   = 8;
  localparam int PAD = 2;
  localparam int WIN = 9;

  logic clk = 1'b0;
  logic reset;

  pong_engine_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  pong_engine #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .PAD_SIZE  (PAD),
    .WIN_SCORE (WIN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Game model: state 0..3, ball position, direction as +1/-1, scores.
  int           m_state = 0, m_bx = W / 2, m_by = H / 2, m_dx = 1, m_dy = 1;
  int           m_st = 0, m_sd = 0;
  bit           m_ht = 1'b0, m_hd = 1'b0, m_pt = 1'b0, m_pd = 1'b0;
  logic [W-1:0] m_mat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit on_pad(int p, int c);
    int q;
    q = (p > W - PAD) ? W - PAD : p;
    return (c >= q) && (c < q + PAD);
  endfunction

  function automatic bit returns_ball(int p, int x);
    for (int c = x - 1; c <= x + 1; c++) begin
      if (c >= 0 && c < W && on_pad(p, c)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] draw(int row, int pt, int pd, bit ball, int bx, int by);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < W; c++) begin
      if (row == 0 && on_pad(pt, c)) r[c] = 1'b1;
      if (row == H - 1 && on_pad(pd, c)) r[c] = 1'b1;
      if (ball && row == by && c == bx) r[c] = 1'b1;
    end
    return r;
  endfunction

  task automatic new_game();
    m_state = 1; m_st = 0; m_sd = 0;
    m_bx = W / 2; m_by = H / 2; m_dx = 1; m_dy = 1;
  endtask

  task automatic model_step();
    m_ht = 1'b0; m_hd = 1'b0; m_pt = 1'b0; m_pd = 1'b0;
    if (reset) begin
      m_state = 0; m_st = 0; m_sd = 0;
      m_bx = W / 2; m_by = H / 2; m_dx = 1; m_dy = 1;
      m_mat = '0;
    end else begin
      m_mat = draw(bus.row_sel, bus.player_top, bus.player_down, m_state != 0, m_bx, m_by);
      case (m_state)
        0, 3: if (bus.start) new_game();
        1: if (bus.tick) begin
          if ((m_bx == 0 && m_dx < 0) || (m_bx == W - 1 && m_dx > 0)) m_dx = -m_dx;
          if (m_by == 1 && m_dy < 0) begin
            if (returns_ball(bus.player_top, m_bx)) begin
              m_ht = 1'b1; m_dy = 1; m_by = 2;
            end else begin
              m_pd = 1'b1; m_by = 0; m_sd++; m_state = 2;
            end
          end else if (m_by == H - 2 && m_dy > 0) begin
            if (returns_ball(bus.player_down, m_bx)) begin
              m_hd = 1'b1; m_dy = -1; m_by = H - 3;
            end else begin
              m_pt = 1'b1; m_by = H - 1; m_st++; m_state = 2;
            end
          end else begin
            m_by = m_by + m_dy;
          end
          m_bx = m_bx + m_dx;
        end
        2: begin
          if (m_st == WIN || m_sd == WIN) m_state = 3;
          else if (bus.start) begin
            m_state = 1; m_bx = W / 2; m_by = H / 2;
          end
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("state",      32'(bus.state),      32'(m_state));
    check("ball_x",     32'(bus.ball_x),     32'(m_bx));
    check("ball_y",     32'(bus.ball_y),     32'(m_by));
    check("score_top",  32'(bus.score_top),  32'(m_st));
    check("score_down", 32'(bus.score_down), 32'(m_sd));
    check("hit_top",    32'(bus.hit_top),    32'(m_ht));
    check("hit_down",   32'(bus.hit_down),   32'(m_hd));
    check("point_top",  32'(bus.point_top),  32'(m_pt));
    check("point_down", 32'(bus.point_down), 32'(m_pd));
    check("matrix_out", 32'(bus.matrix_out), 32'(m_mat));
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_ball(input string name, input int x, input int y);
    check({name, "_x"}, 32'(bus.ball_x), 32'(x));
    check({name, "_y"}, 32'(bus.ball_y), 32'(y));
  endtask

  initial begin
    reset = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0;
    bus.player_top = 3'd3; bus.player_down = 3'd7; bus.row_sel = 3'd0;
    cyc(2);
    check("rst_state", 32'(bus.state), 32'd0);
    check_ball("rst_ball", 4, 4);
    check("rst_matrix", 32'(bus.matrix_out), 32'd0);

    reset = 1'b0; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("start_state", 32'(bus.state), 32'd1);
    cyc();
    check("row0", 32'(bus.matrix_out), 32'(8'b0001_1000));
    bus.row_sel = 3'd4;
    cyc();
    check("row4", 32'(bus.matrix_out), 32'(8'b0001_0000));
    bus.row_sel = 3'd7;
    cyc();
    check("row7_clamp", 32'(bus.matrix_out), 32'(8'b1100_0000));

    bus.player_top = 3'd0; bus.tick = 1'b1;
    cyc(2);
    check_ball("t2", 6, 6);
    cyc();
    check("hit_down", 32'(bus.hit_down), 32'd1);
    check_ball("t3", 7, 5);
    cyc();
    check("hit_down_once", 32'(bus.hit_down), 32'd0);
    check_ball("wall", 6, 4);
    cyc(4);
    check_ball("miss", 2, 0);
    check("point_down", 32'(bus.point_down), 32'd1);
    check("score_down", 32'(bus.score_down), 32'd1);
    check("point_state", 32'(bus.state), 32'd2);

    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("serve_state", 32'(bus.state), 32'd1);
    check_ball("serve", 4, 4);
    cyc(3);
    check_ball("approach", 1, 1);
    cyc();
    check("hit_top", 32'(bus.hit_top), 32'd1);
    check_ball("ret", 0, 2);

    reset = 1'b1;
    cyc();
    check("midrst_state", 32'(bus.state), 32'd0);
    check_ball("midrst", 4, 4);
    check("midrst_score", 32'(bus.score_down), 32'd0);
    check("midrst_matrix", 32'(bus.matrix_out), 32'd0);
    reset = 1'b0; bus.tick = 1'b0;

    for (int i = 0; i < 6000; i++) begin
      reset     = ($urandom_range(0, 999) == 0);
      bus.tick  = 1'($urandom_range(0, 1));
      bus.start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.player_top  = 3'($urandom_range(0, W - 1));
        bus.player_down = 3'($urandom_range(0, W - 1));
      end
      bus.row_sel = 3'($urandom_range(0, H - 1));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
